// File: rtl/coherent_bus_ctrl.sv
// coherent_bus_ctrl
//   MESI snooping bus controller between CPUS private L1 data caches and a
//   shared word-wide L2. Serialises BusRd / BusRdX / BusInv / evict requests,
//   runs the snoop phase, cache-to-cache transfers, BLOCK_WORDS-beat L2
//   bursts and the writeback of a dirty supplier on a BusRd.
//
//   Configuration macro: RR_ARB_EN
//     defined   : round-robin arbitration within the winning request class
//     undefined : fixed priority, highest CPU index wins
//
//   Ports
//     CLK, RST           clock, asynchronous active-high reset
//     dREN/dWEN/ccwrite  per-CPU read-miss / evict / write-intent requests
//     daddr, dstore      per-CPU request address and block data
//     dload, dwait       block returned to requester, completion strobe (active low)
//     ccsnoopaddr        registered block-aligned snoop address per CPU
//     ccwait, ccinv      snoop / invalidate command to non-requesters
//     ccsnoopdone/hit    snoop lookup finished / snooper holds the block
//     ccdirty            snooper copy is Modified
//     ccexclusive        requester installs in E (with the dwait pulse)
//     l2REN/l2WEN        L2 read / write beat request
//     l2addr, l2store    registered L2 word address, L2 write data
//     l2load, l2ready    L2 read data, beat accepted / valid
//     abort_bus          abandon the current transaction
module coherent_bus_ctrl #(
    parameter int unsigned CPUS        = 4,
    parameter int unsigned BLOCK_WORDS = 2,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [CPUS-1:0]                 dREN,
    input  logic [CPUS-1:0]                 dWEN,
    input  logic [CPUS-1:0]                 ccwrite,
    input  logic [CPUS*ADDR_W-1:0]          daddr,
    input  logic [CPUS*BLOCK_WORDS*32-1:0]  dstore,
    output logic [CPUS*BLOCK_WORDS*32-1:0]  dload,
    output logic [CPUS-1:0]                 dwait,
    output logic [CPUS*ADDR_W-1:0]          ccsnoopaddr,
    output logic [CPUS-1:0]                 ccwait,
    output logic [CPUS-1:0]                 ccinv,
    input  logic [CPUS-1:0]                 ccsnoopdone,
    input  logic [CPUS-1:0]                 ccsnoophit,
    input  logic [CPUS-1:0]                 ccdirty,
    output logic [CPUS-1:0]                 ccexclusive,
    output logic                            l2REN,
    output logic                            l2WEN,
    output logic [ADDR_W-1:0]               l2addr,
    output logic [31:0]                     l2store,
    input  logic [31:0]                     l2load,
    input  logic                            l2ready,
    input  logic                            abort_bus
);

    localparam int unsigned IDX_W  = $clog2(CPUS);
    localparam int unsigned BEAT_W = $clog2(BLOCK_WORDS) + 1;
    localparam int unsigned WIDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int unsigned BLK_W  = BLOCK_WORDS * 32;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLOCK_WORDS * 4 - 1);

    typedef logic [BLOCK_WORDS-1:0][31:0] block_t;

    typedef enum logic [3:0] {
        S_IDLE, S_GRANT, S_SNOOP, S_TRANSFER, S_READ_L2,
        S_WRITEBACK, S_WB_SUPPLIER, S_FILL, S_INVALIDATE
    } state_t;

    typedef enum logic [1:0] {OP_RD, OP_RDX, OP_INV, OP_EVICT} op_t;

    state_t              state_q, state_d;
    op_t                 op_q, op_d;
    logic [IDX_W-1:0]    req_q, req_d;
    logic [IDX_W-1:0]    sup_q, sup_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                excl_q, excl_d;
    logic                sup_dirty_q, sup_dirty_d;
    logic                wb_first_q, wb_first_d;
    logic [ADDR_W-1:0]   l2addr_q, l2addr_d;
    block_t              dload_q [CPUS];
    block_t              dload_d [CPUS];
    logic [ADDR_W-1:0]   snoopaddr_q [CPUS];
    logic [ADDR_W-1:0]   snoopaddr_d [CPUS];
`ifdef RR_ARB_EN
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    cand;
    logic                found;
`endif

    logic [ADDR_W-1:0]   daddr_a  [CPUS];
    block_t              dstore_a [CPUS];

    for (genvar c = 0; c < CPUS; c++) begin : g_port
        assign daddr_a[c]                       = daddr[c*ADDR_W +: ADDR_W];
        assign dstore_a[c]                      = dstore[c*BLK_W +: BLK_W];
        assign dload[c*BLK_W +: BLK_W]          = dload_q[c];
        assign ccsnoopaddr[c*ADDR_W +: ADDR_W]  = snoopaddr_q[c];
    end

    assign l2addr = l2addr_q;

    // Arbiter: class priority first, then one CPU inside the winning class.
    logic [CPUS-1:0]   cls_mask;
    op_t               cls_op;
    logic [IDX_W-1:0]  win_idx;
    logic [ADDR_W-1:0] win_base;

    always_comb begin
        cls_mask = '0;
        cls_op   = OP_RD;
        win_idx  = '0;
        if (|dWEN) begin
            cls_mask = dWEN;
            cls_op   = OP_EVICT;
        end else if (|(dREN & ccwrite)) begin
            cls_mask = dREN & ccwrite;
            cls_op   = OP_RDX;
        end else if (|dREN) begin
            cls_mask = dREN;
            cls_op   = OP_RD;
        end else if (|ccwrite) begin
            cls_mask = ccwrite;
            cls_op   = OP_INV;
        end
`ifdef RR_ARB_EN
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < CPUS; k++) begin
            cand = rr_ptr_q + IDX_W'(k);  // wraps modulo CPUS
            if (!found && cls_mask[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
`else
        for (int unsigned i = 0; i < CPUS; i++) begin
            if (cls_mask[i]) win_idx = IDX_W'(i);
        end
`endif
        win_base = daddr_a[win_idx] & ~OFF_MASK;
    end

    // Snoop response decode over non-requesters only.
    logic [CPUS-1:0]  nr_mask;
    logic [CPUS-1:0]  hits;
    logic             all_done;
    logic [IDX_W-1:0] hit_idx;
    logic [WIDX_W-1:0] beat_idx;

    always_comb begin
        nr_mask  = ~(CPUS'(1) << req_q);
        hits     = ccsnoophit & nr_mask;
        all_done = &(ccsnoopdone | ~nr_mask);
        beat_idx = WIDX_W'(beat_q);
        hit_idx  = '0;
        for (int unsigned i = 0; i < CPUS; i++) begin
            if (hits[CPUS-1-i]) hit_idx = IDX_W'(CPUS - 1 - i);  // lowest index wins
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        req_d       = req_q;
        sup_d       = sup_q;
        base_d      = base_q;
        beat_d      = beat_q;
        excl_d      = excl_q;
        sup_dirty_d = sup_dirty_q;
        wb_first_d  = 1'b0;
        l2addr_d    = l2addr_q;
        dload_d     = dload_q;
        snoopaddr_d = snoopaddr_q;
`ifdef RR_ARB_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        ccexclusive = '0;
        l2REN       = 1'b0;
        l2WEN       = 1'b0;
        l2store     = '0;

        if (abort_bus) begin
            state_d = S_IDLE;
            beat_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (|cls_mask) begin
                        state_d = S_GRANT;
                        op_d    = cls_op;
                        req_d   = win_idx;
                        base_d  = win_base;
                        for (int unsigned i = 0; i < CPUS; i++) begin
                            if (IDX_W'(i) != win_idx) snoopaddr_d[i] = win_base;
                        end
`ifdef RR_ARB_EN
                        rr_ptr_d = win_idx + IDX_W'(1);
`endif
                    end
                end
                S_GRANT: begin
                    if (op_q == OP_EVICT) begin
                        // Data is taken from dstore during WRITEBACK, so the
                        // requester is released as soon as the bus is owned.
                        dwait[req_q] = 1'b0;
                        state_d      = S_WRITEBACK;
                        beat_d       = '0;
                    end else begin
                        state_d = S_SNOOP;
                    end
                end
                S_SNOOP: begin
                    ccwait = nr_mask;
                    if (op_q == OP_RDX || op_q == OP_INV) ccinv = nr_mask;
                    if (all_done) begin
                        if (op_q == OP_INV) begin
                            excl_d  = 1'b0;
                            state_d = S_INVALIDATE;
                        end else begin
                            excl_d = ~|hits;
                            if (|hits) begin
                                sup_d       = hit_idx;
                                sup_dirty_d = ccdirty[hit_idx];
                                state_d     = S_TRANSFER;
                            end else begin
                                beat_d  = '0;
                                state_d = S_READ_L2;
                            end
                        end
                    end
                end
                S_TRANSFER: begin
                    dload_d[req_q] = dstore_a[sup_q];
                    if (sup_dirty_q && op_q == OP_RD) begin
                        beat_d     = '0;
                        wb_first_d = 1'b1;
                        state_d    = S_WB_SUPPLIER;
                    end else begin
                        state_d = S_FILL;
                    end
                end
                S_READ_L2: begin
                    l2REN = 1'b1;
                    if (l2ready) begin
                        dload_d[req_q][beat_idx] = l2load;
                        if (beat_q == BEAT_W'(BLOCK_WORDS - 1)) begin
                            beat_d  = '0;
                            state_d = S_FILL;
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                        end
                    end
                end
                S_WRITEBACK, S_WB_SUPPLIER: begin
                    l2WEN = 1'b1;
                    // A dirty supplier's block was already copied into the
                    // requester's dload, so it is written back from there.
                    if (state_q == S_WRITEBACK) l2store = dstore_a[req_q][beat_idx];
                    else                        l2store = dload_q[req_q][beat_idx];
                    if (state_q == S_WB_SUPPLIER && wb_first_q) begin
                        dwait[req_q]       = 1'b0;
                        ccexclusive[req_q] = excl_q;
                    end
                    if (l2ready) begin
                        if (beat_q == BEAT_W'(BLOCK_WORDS - 1)) begin
                            beat_d  = '0;
                            state_d = S_IDLE;
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                        end
                    end
                end
                S_FILL, S_INVALIDATE: begin
                    dwait[req_q]       = 1'b0;
                    ccexclusive[req_q] = excl_q;
                    state_d            = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // l2addr is registered, so it is computed from the next beat.
        if (state_d == S_READ_L2 || state_d == S_WRITEBACK || state_d == S_WB_SUPPLIER) begin
            l2addr_d = base_d + (ADDR_W'(beat_d) << 2);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            op_q        <= OP_RD;
            req_q       <= '0;
            sup_q       <= '0;
            base_q      <= '0;
            beat_q      <= '0;
            excl_q      <= 1'b0;
            sup_dirty_q <= 1'b0;
            wb_first_q  <= 1'b0;
            l2addr_q    <= '0;
            dload_q     <= '{default: '0};
            snoopaddr_q <= '{default: '0};
`ifdef RR_ARB_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            req_q       <= req_d;
            sup_q       <= sup_d;
            base_q      <= base_d;
            beat_q      <= beat_d;
            excl_q      <= excl_d;
            sup_dirty_q <= sup_dirty_d;
            wb_first_q  <= wb_first_d;
            l2addr_q    <= l2addr_d;
            dload_q     <= dload_d;
            snoopaddr_q <= snoopaddr_d;
`ifdef RR_ARB_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

endmodule
